// File: rtl/text_stamper.sv
// text_stamper
//   Stamps a fixed-length string from a parameterised table into a character display.
//   Each new placement first blanks the previously stamped string (when one exists),
//   then writes the new string starting at the clamped, switch-selected cell.
//
// Ports
//   CLK        in   clock
//   NRST       in   synchronous active-low reset
//   KEY_N      in   asynchronous trigger button, active-low
//   POS_X      in   requested start column
//   POS_Y      in   requested start row
//   STR_SEL    in   string index (>= NUM_STR writes BLANK)
//   MODE_ERASE in   1 = erase previous string only
//   CX/CY/CHAR out  character-plane write column / row / data
//   CWE        out  write strobe
//   BUSY       out  high whenever the FSM is not idle
//   DONE       out  one-cycle pulse at the end of an operation
module text_stamper #(
   parameter int unsigned CX_W    = 5,
   parameter int unsigned CY_W    = 4,
   parameter int unsigned CHAR_W  = 8,
   parameter int unsigned COLS    = 32,
   parameter int unsigned ROWS    = 16,
   parameter int unsigned STR_LEN = 9,
   parameter int unsigned NUM_STR = 4,
   // Derived from NUM_STR; leave at its default.
   parameter int unsigned SEL_W   = (NUM_STR > 1) ? $clog2(NUM_STR) : 1,
   parameter logic [CHAR_W-1:0] BLANK = CHAR_W'(8'h20),
   parameter logic [NUM_STR*STR_LEN*CHAR_W-1:0] STR_TABLE = {(NUM_STR*STR_LEN){BLANK}}
) (
   input  logic              CLK,
   input  logic              NRST,
   input  logic              KEY_N,
   input  logic [CX_W-1:0]   POS_X,
   input  logic [CY_W-1:0]   POS_Y,
   input  logic [SEL_W-1:0]  STR_SEL,
   input  logic              MODE_ERASE,
   output logic [CX_W-1:0]   CX,
   output logic [CY_W-1:0]   CY,
   output logic [CHAR_W-1:0] CHAR,
   output logic              CWE,
   output logic              BUSY,
   output logic              DONE
);

   localparam int unsigned TBL_W = NUM_STR * STR_LEN * CHAR_W;
   localparam int unsigned IDX_W = (STR_LEN > 1) ? $clog2(STR_LEN) : 1;
   localparam logic [CX_W-1:0]  CX_MAX   = CX_W'(COLS - 1);
   localparam logic [CY_W-1:0]  CY_MAX   = CY_W'(ROWS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STR_LEN - 1);

   typedef enum logic [1:0] {StIdle, StErase, StWrite, StFinish} state_t;

   // Key synchroniser and edge detector
   logic r_key_s1, r_key_s2, r_key_s3;
   logic r_v1, r_v2;
   logic w_trig;

   // r_v2 marks r_key_s2 as holding a real sample; until then the edge flop stays low so a
   // key held through reset release never reads as a fresh press.
   always_ff @(posedge CLK) begin
      if (!NRST) begin
         r_key_s1 <= 1'b1;
         r_key_s2 <= 1'b1;
         r_key_s3 <= 1'b0;
         r_v1     <= 1'b0;
         r_v2     <= 1'b0;
      end else begin
         r_key_s1 <= KEY_N;
         r_key_s2 <= r_key_s1;
         r_key_s3 <= r_key_s2 & r_v2;
         r_v1     <= 1'b1;
         r_v2     <= r_v1;
      end
   end

   assign w_trig = r_key_s3 & ~r_key_s2;

   // Clamped request sampled from the switches
   logic [CX_W-1:0] w_req_x;
   logic [CY_W-1:0] w_req_y;
   assign w_req_x = (32'(POS_X) >= COLS) ? CX_MAX : POS_X;
   assign w_req_y = (32'(POS_Y) >= ROWS) ? CY_MAX : POS_Y;

   // State
   state_t             r_state, w_state_nxt;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [CX_W-1:0]    r_cx, w_cx_nxt;
   logic [CY_W-1:0]    r_cy, w_cy_nxt;
   logic [CX_W-1:0]    r_lat_x, w_lat_x_nxt;
   logic [CY_W-1:0]    r_lat_y, w_lat_y_nxt;
   logic [SEL_W-1:0]   r_lat_sel, w_lat_sel_nxt;
   logic               r_lat_erase, w_lat_erase_nxt;
   logic               r_pend, w_pend_nxt;
   logic [CX_W-1:0]    r_pend_x, w_pend_x_nxt;
   logic [CY_W-1:0]    r_pend_y, w_pend_y_nxt;
   logic [SEL_W-1:0]   r_pend_sel, w_pend_sel_nxt;
   logic               r_pend_erase, w_pend_erase_nxt;
   logic [CX_W-1:0]    r_prev_x, w_prev_x_nxt;
   logic [CY_W-1:0]    r_prev_y, w_prev_y_nxt;
   logic               r_prev_valid, w_prev_valid_nxt;

   always_ff @(posedge CLK) begin
      if (!NRST) begin
         r_state      <= StIdle;
         r_idx        <= '0;
         r_cx         <= '0;
         r_cy         <= '0;
         r_lat_x      <= '0;
         r_lat_y      <= '0;
         r_lat_sel    <= '0;
         r_lat_erase  <= 1'b0;
         r_pend       <= 1'b0;
         r_pend_x     <= '0;
         r_pend_y     <= '0;
         r_pend_sel   <= '0;
         r_pend_erase <= 1'b0;
         r_prev_x     <= '0;
         r_prev_y     <= '0;
         r_prev_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_cx         <= w_cx_nxt;
         r_cy         <= w_cy_nxt;
         r_lat_x      <= w_lat_x_nxt;
         r_lat_y      <= w_lat_y_nxt;
         r_lat_sel    <= w_lat_sel_nxt;
         r_lat_erase  <= w_lat_erase_nxt;
         r_pend       <= w_pend_nxt;
         r_pend_x     <= w_pend_x_nxt;
         r_pend_y     <= w_pend_y_nxt;
         r_pend_sel   <= w_pend_sel_nxt;
         r_pend_erase <= w_pend_erase_nxt;
         r_prev_x     <= w_prev_x_nxt;
         r_prev_y     <= w_prev_y_nxt;
         r_prev_valid <= w_prev_valid_nxt;
      end
   end

   // Cursor advance with row and screen wrap
   logic [CX_W-1:0] w_cx_inc;
   logic [CY_W-1:0] w_cy_inc;
   assign w_cx_inc = (r_cx == CX_MAX) ? '0 : r_cx + 1'b1;
   assign w_cy_inc = (r_cx != CX_MAX) ? r_cy : ((r_cy == CY_MAX) ? '0 : r_cy + 1'b1);

   // A live trigger beats the pending slot (latest request wins)
   logic [CX_W-1:0]  w_src_x;
   logic [CY_W-1:0]  w_src_y;
   logic [SEL_W-1:0] w_src_sel;
   logic             w_src_erase;
   assign w_src_x     = w_trig ? w_req_x : r_pend_x;
   assign w_src_y     = w_trig ? w_req_y : r_pend_y;
   assign w_src_sel   = w_trig ? STR_SEL : r_pend_sel;
   assign w_src_erase = w_trig ? MODE_ERASE : r_pend_erase;

   always_comb begin
      w_state_nxt      = r_state;
      w_idx_nxt        = r_idx;
      w_cx_nxt         = r_cx;
      w_cy_nxt         = r_cy;
      w_lat_x_nxt      = r_lat_x;
      w_lat_y_nxt      = r_lat_y;
      w_lat_sel_nxt    = r_lat_sel;
      w_lat_erase_nxt  = r_lat_erase;
      w_pend_nxt       = r_pend;
      w_pend_x_nxt     = r_pend_x;
      w_pend_y_nxt     = r_pend_y;
      w_pend_sel_nxt   = r_pend_sel;
      w_pend_erase_nxt = r_pend_erase;
      w_prev_x_nxt     = r_prev_x;
      w_prev_y_nxt     = r_prev_y;
      w_prev_valid_nxt = r_prev_valid;

      // Any trigger outside IDLE (FINISH included) lands in the pending slot
      if (w_trig && (r_state != StIdle)) begin
         w_pend_nxt       = 1'b1;
         w_pend_x_nxt     = w_req_x;
         w_pend_y_nxt     = w_req_y;
         w_pend_sel_nxt   = STR_SEL;
         w_pend_erase_nxt = MODE_ERASE;
      end

      unique case (r_state)
         StIdle: begin
            if (w_trig || r_pend) begin
               w_pend_nxt      = 1'b0;
               w_lat_x_nxt     = w_src_x;
               w_lat_y_nxt     = w_src_y;
               w_lat_sel_nxt   = w_src_sel;
               w_lat_erase_nxt = w_src_erase;
               w_idx_nxt       = '0;
               if (r_prev_valid) begin
                  w_state_nxt = StErase;
                  w_cx_nxt    = r_prev_x;
                  w_cy_nxt    = r_prev_y;
               end else if (w_src_erase) begin
                  w_state_nxt = StFinish;
               end else begin
                  w_state_nxt = StWrite;
                  w_cx_nxt    = w_src_x;
                  w_cy_nxt    = w_src_y;
               end
            end
         end
         StErase: begin
            if (r_idx == IDX_LAST) begin
               w_idx_nxt = '0;
               if (r_lat_erase) begin
                  w_state_nxt = StFinish;
               end else begin
                  w_state_nxt = StWrite;
                  w_cx_nxt    = r_lat_x;
                  w_cy_nxt    = r_lat_y;
               end
            end else begin
               w_idx_nxt = r_idx + 1'b1;
               w_cx_nxt  = w_cx_inc;
               w_cy_nxt  = w_cy_inc;
            end
         end
         StWrite: begin
            if (r_idx == IDX_LAST) begin
               w_idx_nxt   = '0;
               w_state_nxt = StFinish;
            end else begin
               w_idx_nxt = r_idx + 1'b1;
               w_cx_nxt  = w_cx_inc;
               w_cy_nxt  = w_cy_inc;
            end
         end
         StFinish: begin
            w_state_nxt = StIdle;
            if (r_lat_erase) begin
               w_prev_valid_nxt = 1'b0;
            end else begin
               w_prev_x_nxt     = r_lat_x;
               w_prev_y_nxt     = r_lat_y;
               w_prev_valid_nxt = 1'b1;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // String table lookup; an out-of-range selector reads as BLANK
   logic              w_sel_ok;
   int unsigned       w_tbl_bit;
   logic [TBL_W-1:0]  w_tbl_word;
   logic [CHAR_W-1:0] w_tbl_char;

   always_comb begin
      w_sel_ok   = (32'(r_lat_sel) < NUM_STR);
      w_tbl_bit  = 0;
      if (w_sel_ok) begin
         w_tbl_bit = (32'(r_lat_sel) * STR_LEN + 32'(r_idx)) * CHAR_W;
      end
      w_tbl_word = STR_TABLE >> w_tbl_bit;
      w_tbl_char = w_sel_ok ? w_tbl_word[CHAR_W-1:0] : BLANK;
   end

   assign CX   = r_cx;
   assign CY   = r_cy;
   assign CWE  = (r_state == StErase) || (r_state == StWrite);
   assign CHAR = (r_state == StErase) ? BLANK :
                 (r_state == StWrite) ? w_tbl_char : '0;
   assign BUSY = (r_state != StIdle);
   assign DONE = (r_state == StFinish);

endmodule

// File: tb/tb_text_stamper.sv
// tb_text_stamper
//   Self-checking bench for text_stamper: a table of hand-computed presses, random presses
//   against a linear-address screen model, plus queueing and reset sequences.
module tb_text_stamper;

   localparam int CX_W     = 5;
   localparam int CY_W     = 4;
   localparam int CHAR_W   = 8;
   localparam int COLS     = 30;
   localparam int ROWS     = 14;
   localparam int STR_LEN  = 9;
   localparam int NUM_STR  = 3;
   localparam int SEL_W    = 2;
   localparam int TBL_BITS = NUM_STR * STR_LEN * CHAR_W;

   // Char i of string s is 'A' + 16*s + i
   function automatic logic [TBL_BITS-1:0] make_table();
      logic [TBL_BITS-1:0] t;
      t = '0;
      for (int s = 0; s < NUM_STR; s++)
         for (int i = 0; i < STR_LEN; i++)
            t[(s*STR_LEN+i)*CHAR_W +: CHAR_W] = 8'(8'h41 + 16 * s + i);
      return t;
   endfunction
   localparam logic [TBL_BITS-1:0] TABLE = make_table();

   logic              CLK = 1'b0;
   logic              NRST;
   logic              KEY_N;
   logic [CX_W-1:0]   POS_X;
   logic [CY_W-1:0]   POS_Y;
   logic [SEL_W-1:0]  STR_SEL;
   logic              MODE_ERASE;
   logic [CX_W-1:0]   CX;
   logic [CY_W-1:0]   CY;
   logic [CHAR_W-1:0] CHAR;
   logic              CWE;
   logic              BUSY;
   logic              DONE;

   text_stamper #(
      .CX_W(CX_W), .CY_W(CY_W), .CHAR_W(CHAR_W), .COLS(COLS), .ROWS(ROWS),
      .STR_LEN(STR_LEN), .NUM_STR(NUM_STR), .SEL_W(SEL_W), .BLANK(8'h20), .STR_TABLE(TABLE)
   ) u_dut (
      .CLK(CLK), .NRST(NRST), .KEY_N(KEY_N), .POS_X(POS_X), .POS_Y(POS_Y),
      .STR_SEL(STR_SEL), .MODE_ERASE(MODE_ERASE), .CX(CX), .CY(CY), .CHAR(CHAR),
      .CWE(CWE), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {int cyc; int x; int y; int ch;} wr_t;
   wr_t got_q[$];
   wr_t exp_q[$];
   int  done_q[$];
   int  exp_done_q[$];

   always @(negedge CLK) begin
      if (CWE === 1'b1) got_q.push_back('{cyc, int'(CX), int'(CY), int'(CHAR)});
      if (DONE === 1'b1) done_q.push_back(cyc);
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic tickn(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear();
      got_q.delete();
      exp_q.delete();
      done_q.delete();
      exp_done_q.delete();
   endtask

   // Screen model: previous stamp position, addresses as y*COLS+x modulo screen size
   int m_px = 0;
   int m_py = 0;
   bit m_pv = 1'b0;

   function automatic int exp_char(input int sel, input int i);
      return (sel < NUM_STR) ? 65 + 16 * sel + i : 32;
   endfunction

   task automatic model_op(input int x, input int y, input int sel, input int er,
                           input int fc, output int w);
      int cx, cy, p, n;
      n  = COLS * ROWS;
      cx = (x >= COLS) ? COLS - 1 : x;
      cy = (y >= ROWS) ? ROWS - 1 : y;
      w  = 0;
      if (m_pv) begin
         for (int k = 0; k < STR_LEN; k++) begin
            p = (m_py * COLS + m_px + k) % n;
            exp_q.push_back('{fc + w, p % COLS, p / COLS, 32});
            w++;
         end
      end
      if (er == 0) begin
         for (int k = 0; k < STR_LEN; k++) begin
            p = (cy * COLS + cx + k) % n;
            exp_q.push_back('{fc + w, p % COLS, p / COLS, exp_char(sel, k)});
            w++;
         end
         m_px = cx;
         m_py = cy;
         m_pv = 1'b1;
      end else begin
         m_pv = 1'b0;
      end
   endtask

   task automatic compare(input string tag);
      chk({tag, " write count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_chk++;
         if (got_q[i].cyc != exp_q[i].cyc || got_q[i].x != exp_q[i].x ||
             got_q[i].y != exp_q[i].y || got_q[i].ch != exp_q[i].ch) begin
            n_fail++;
            $display("FAIL %s write %0d: got cyc=%0d pos=(%0d,%0d) ch=%0h, expected cyc=%0d pos=(%0d,%0d) ch=%0h",
                     tag, i, got_q[i].cyc, got_q[i].x, got_q[i].y, got_q[i].ch,
                     exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].ch);
         end
      end
      chk({tag, " done count"}, done_q.size(), exp_done_q.size());
      for (int i = 0; i < exp_done_q.size() && i < done_q.size(); i++)
         chk({tag, " done cycle"}, done_q[i], exp_done_q[i]);
   endtask

   // One press: trigger lands 2 cycles after KEY_N falls, first write one cycle later
   task automatic press(input int x, input int y, input int sel, input int er,
                        input string tag);
      int c0, w;
      clear();
      POS_X      = 5'(x);
      POS_Y      = 4'(y);
      STR_SEL    = 2'(sel);
      MODE_ERASE = (er != 0);
      KEY_N      = 1'b0;
      c0         = cyc;
      model_op(x, y, sel, er, c0 + 3, w);
      exp_done_q.push_back(c0 + 3 + w);
      for (int i = 0; i < 100 && done_q.size() == 0; i++) tick();
      tick();
      KEY_N = 1'b1;
      tickn(4);
      compare(tag);
      chk({tag, " idle after"}, int'(BUSY), 0);
   endtask

   typedef struct {int x; int y; int sel; int er; int w; int fx; int fy; int lx; int ly; int lch;}
      vec_t;
   vec_t vt[7];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0, w1, w2, nb;

      vt[0] = '{3,  2,  0, 0, 9,  3,  2,  11, 2, 'h49};
      vt[1] = '{10, 5,  1, 0, 18, 3,  2,  18, 5, 'h59};
      vt[2] = '{26, 13, 2, 0, 18, 10, 5,  4,  0, 'h69};
      vt[3] = '{31, 15, 3, 0, 18, 26, 13, 7,  0, 'h20};
      vt[4] = '{0,  0,  0, 1, 9,  29, 13, 7,  0, 'h20};
      vt[5] = '{5,  5,  1, 1, 0,  0,  0,  0,  0, 0};
      vt[6] = '{0,  0,  0, 0, 9,  0,  0,  8,  0, 'h49};

      NRST = 1'b0; KEY_N = 1'b1; POS_X = '0; POS_Y = '0; STR_SEL = '0; MODE_ERASE = 1'b0;
      tickn(3);
      chk("reset CX", int'(CX), 0);
      chk("reset CY", int'(CY), 0);
      chk("reset CHAR", int'(CHAR), 0);
      chk("reset CWE", int'(CWE), 0);
      chk("reset BUSY", int'(BUSY), 0);
      chk("reset DONE", int'(DONE), 0);
      NRST = 1'b1;
      tickn(4);

      for (int i = 0; i < 7; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         press(vt[i].x, vt[i].y, vt[i].sel, vt[i].er, tag);
         chk({tag, " W"}, got_q.size(), vt[i].w);
         if (vt[i].w > 0 && got_q.size() > 0) begin
            chk({tag, " first x"}, got_q[0].x, vt[i].fx);
            chk({tag, " first y"}, got_q[0].y, vt[i].fy);
            chk({tag, " last x"}, got_q[got_q.size()-1].x, vt[i].lx);
            chk({tag, " last y"}, got_q[got_q.size()-1].y, vt[i].ly);
            chk({tag, " last char"}, got_q[got_q.size()-1].ch, vt[i].lch);
         end
      end

      for (int i = 0; i < 24; i++) begin
         press(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 1 : 0,
               $sformatf("rand%0d", i));
      end

      // Three presses while busy; the last lands on the FINISH cycle and wins
      press(12, 3, 1, 0, "pre-queue");
      clear();
      POS_X = 5'd1; POS_Y = 4'd1; STR_SEL = 2'd0; MODE_ERASE = 1'b0; KEY_N = 1'b0;
      c0 = cyc;
      model_op(1, 1, 0, 0, c0 + 3, w1);
      exp_done_q.push_back(c0 + 3 + w1);
      tickn(3); KEY_N = 1'b1; POS_X = 5'd20; POS_Y = 4'd7; STR_SEL = 2'd1;
      tickn(3); KEY_N = 1'b0;
      tickn(3); KEY_N = 1'b1; POS_X = 5'd2; POS_Y = 4'd9; STR_SEL = 2'd2;
      tickn(3); KEY_N = 1'b0;
      tickn(3); KEY_N = 1'b1; POS_X = 5'd15; POS_Y = 4'd12; STR_SEL = 2'd3;
      tickn(4); KEY_N = 1'b0;
      model_op(15, 12, 3, 0, c0 + 3 + w1 + 2, w2);
      exp_done_q.push_back(c0 + 3 + w1 + 2 + w2);
      for (int i = 0; i < 150 && done_q.size() < 2; i++) tick();
      tick();
      KEY_N = 1'b1;
      tickn(8);
      compare("queue");

      // Key held low across reset release must not trigger
      KEY_N = 1'b0;
      NRST  = 1'b0;
      tickn(3);
      NRST = 1'b1;
      m_pv = 1'b0;
      clear();
      tickn(12);
      chk("held key writes", got_q.size(), 0);
      chk("held key done", done_q.size(), 0);
      chk("held key busy", int'(BUSY), 0);
      KEY_N = 1'b1;
      tickn(4);

      // Reset in the middle of the write phase
      press(4, 4, 0, 0, "pre-reset");
      clear();
      POS_X = 5'd6; POS_Y = 4'd6; STR_SEL = 2'd1; MODE_ERASE = 1'b0; KEY_N = 1'b0;
      tickn(15);
      chk("mid-write CWE", int'(CWE), 1);
      NRST = 1'b0;
      tick();
      chk("abort CWE", int'(CWE), 0);
      chk("abort CX", int'(CX), 0);
      chk("abort CY", int'(CY), 0);
      chk("abort CHAR", int'(CHAR), 0);
      chk("abort BUSY", int'(BUSY), 0);
      chk("abort DONE", int'(DONE), 0);
      nb = got_q.size();
      NRST  = 1'b1;
      KEY_N = 1'b1;
      m_pv  = 1'b0;
      tickn(4);
      chk("no CWE after abort", got_q.size(), nb);
      press(7, 1, 2, 0, "post-reset");
      chk("post-reset W", got_q.size(), STR_LEN);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
